pipelined_control_unit: RTL and testbench

Parametrised successor to the combinational opcode decoder. It decodes the ID-stage opcode and carries the resulting control bundle through registered ID/EX, EX/MEM and MEM/WB stages. Stage-aligned control is presented to the datapath, and the block also handles load-use stall detection, branch flush, global freeze, illegal-opcode tagging and retire counting. It sits between instruction fetch/decode and the EX/MEM/WB datapath stages.

---
 rtl/pipelined_control_unit.sv | 247 ++++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes the ID opcode and carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, with load-use stall, flush, freeze and retire counting.
`timescale 1ns/1ps

module pipelined_control_unit #(
  parameter int unsigned REG_ADDR_WIDTH     = 5,
  parameter bit          EXTENDED_OPCODES   = 1'b1,
  parameter bit          HAZARD_DETECT      = 1'b1,
  parameter int unsigned RETIRE_COUNT_WIDTH = 32
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          idValid,
  input  logic [6:0]                    idOpcode,
  input  logic [REG_ADDR_WIDTH-1:0]     idRs1,
  input  logic [REG_ADDR_WIDTH-1:0]     idRs2,
  input  logic [REG_ADDR_WIDTH-1:0]     idRd,
  input  logic                          flushEx,
  input  logic                          freeze,
  output logic                          idStall,
  output logic                          exValid,
  output logic                          exBranchEnable,
  output logic                          exJumpEnable,
  output logic                          exImmediateEnable,
  output logic [1:0]                    exAluOperation,
  output logic [REG_ADDR_WIDTH-1:0]     exRd,
  output logic                          memValid,
  output logic                          memReadEnable,
  output logic                          memWriteEnable,
  output logic [REG_ADDR_WIDTH-1:0]     memRd,
  output logic                          wbValid,
  output logic                          wbRegisterWriteEnable,
  output logic                          wbIllegal,
  output logic [1:0]                    wbSelect,
  output logic [REG_ADDR_WIDTH-1:0]     wbRd,
  output logic [RETIRE_COUNT_WIDTH-1:0] retireCount
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [RETIRE_COUNT_WIDTH-1:0] RETIRE_ONE =
    {{(RETIRE_COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       imm;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic                      valid;
    logic                      branch;
    logic                      jump;
    logic                      imm;
    logic [1:0]                alu_op;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
    logic                      illegal;
    logic [1:0]                wb_sel;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic                      valid;
    logic                      mem_read;
    logic                      mem_write;
    logic                      reg_write;
    logic                      illegal;
    logic [1:0]                wb_sel;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      illegal;
    logic [1:0]                wb_sel;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } mem_wb_t;

  ctrl_t                         dec;
  id_ex_t                        id_ex, id_ex_next;
  ex_mem_t                       ex_mem, ex_mem_next;
  mem_wb_t                       mem_wb, mem_wb_next;
  logic [RETIRE_COUNT_WIDTH-1:0] retire_count;
  logic                          rs1_hit, rs2_hit, load_use;

  // NOTE: every field gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    dec = '0;
    case (idOpcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.imm       = 1'b1;
        dec.alu_op    = 2'b11;
        dec.uses_rs1  = 1'b1;
      end
      OP_LOAD: begin
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = 1'b1;
        dec.wb_sel    = 2'b01;
        dec.uses_rs1  = 1'b1;
      end
      OP_JALR: begin
        dec.branch    = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = 1'b1;
        dec.wb_sel    = 2'b10;
        dec.uses_rs1  = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.imm       = 1'b1;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch    = 1'b1;
        dec.alu_op    = 2'b01;
        dec.uses_rs1  = 1'b1;
        dec.uses_rs2  = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.imm       = 1'b1;
        dec.wb_sel    = 2'b11;
      end
      OP_JAL: begin
        dec.branch    = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = 1'b1;
        dec.wb_sel    = 2'b10;
      end
      OP_FENCE, OP_SYSTEM: dec.illegal = !EXTENDED_OPCODES;
      default:             dec.illegal = 1'b1;
    endcase
  end

  // A load in EX whose result the ID instruction needs one cycle too early.
  assign rs1_hit  = dec.uses_rs1 && (id_ex.rd == idRs1);
  assign rs2_hit  = dec.uses_rs2 && (id_ex.rd == idRs2);
  assign load_use = idValid && id_ex.valid && id_ex.mem_read &&
                    (id_ex.rd != '0) && (rs1_hit || rs2_hit);
  assign idStall  = HAZARD_DETECT && load_use;

  always_comb begin
    id_ex_next = '0;
    if (idValid && !flushEx && !idStall) begin
      id_ex_next.valid     = 1'b1;
      id_ex_next.branch    = dec.branch;
      id_ex_next.jump      = dec.jump;
      id_ex_next.imm       = dec.imm;
      id_ex_next.alu_op    = dec.alu_op;
      id_ex_next.mem_read  = dec.mem_read;
      id_ex_next.mem_write = dec.mem_write;
      id_ex_next.reg_write = dec.reg_write;
      id_ex_next.illegal   = dec.illegal;
      id_ex_next.wb_sel    = dec.wb_sel;
      id_ex_next.rd        = dec.reg_write ? idRd : '0;
    end
  end

  always_comb begin
    ex_mem_next           = '0;
    ex_mem_next.valid     = id_ex.valid;
    ex_mem_next.mem_read  = id_ex.mem_read;
    ex_mem_next.mem_write = id_ex.mem_write;
    ex_mem_next.reg_write = id_ex.reg_write;
    ex_mem_next.illegal   = id_ex.illegal;
    ex_mem_next.wb_sel    = id_ex.wb_sel;
    ex_mem_next.rd        = id_ex.rd;

    mem_wb_next           = '0;
    mem_wb_next.valid     = ex_mem.valid;
    mem_wb_next.reg_write = ex_mem.reg_write;
    mem_wb_next.illegal   = ex_mem.illegal;
    mem_wb_next.wb_sel    = ex_mem.wb_sel;
    mem_wb_next.rd        = ex_mem.rd;
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the previous value of the stage before it, independent of statement order.
  // NOTE: every stage register is reset to a bubble; there is no storage array
  // here, so nothing is left to power up undefined.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      id_ex        <= '0;
      ex_mem       <= '0;
      mem_wb       <= '0;
      retire_count <= '0;
    end else if (!freeze) begin
      id_ex  <= id_ex_next;
      ex_mem <= ex_mem_next;
      mem_wb <= mem_wb_next;
      if (mem_wb.valid && !mem_wb.illegal) begin
        retire_count <= retire_count + RETIRE_ONE;
      end
    end
  end

  assign exValid               = id_ex.valid;
  assign exBranchEnable        = id_ex.branch;
  assign exJumpEnable          = id_ex.jump;
  assign exImmediateEnable     = id_ex.imm;
  assign exAluOperation        = id_ex.alu_op;
  assign exRd                  = id_ex.rd;
  assign memValid              = ex_mem.valid;
  assign memReadEnable         = ex_mem.mem_read;
  assign memWriteEnable        = ex_mem.mem_write;
  assign memRd                 = ex_mem.rd;
  assign wbValid               = mem_wb.valid;
  assign wbRegisterWriteEnable = mem_wb.reg_write;
  assign wbIllegal             = mem_wb.illegal;
  assign wbSelect              = mem_wb.wb_sel;
  assign wbRd                  = mem_wb.rd;
  assign retireCount           = retire_count;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench: decode table vectors, a WB scoreboard queue, hand-written
// corner sequences, and a second instance with FENCE/SYSTEM illegal and a 4-bit retire counter.
`timescale 1ns/1ps

module tb_pipelined_control_unit;

  localparam int W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  logic         clock = 1'b0;
  logic         resetN, idValid, flushEx, freeze;
  logic [6:0]   idOpcode;
  logic [W-1:0] idRs1, idRs2, idRd;

  logic         idStall, exValid, exBranchEnable, exJumpEnable, exImmediateEnable;
  logic [1:0]   exAluOperation;
  logic [W-1:0] exRd, memRd, wbRd;
  logic         memValid, memReadEnable, memWriteEnable;
  logic         wbValid, wbRegisterWriteEnable, wbIllegal;
  logic [1:0]   wbSelect;
  logic [31:0]  retireCount;

  logic         a_idStall, a_exValid, a_exBranchEnable, a_exJumpEnable, a_exImmediateEnable;
  logic [1:0]   a_exAluOperation;
  logic [W-1:0] a_exRd, a_memRd, a_wbRd;
  logic         a_memValid, a_memReadEnable, a_memWriteEnable;
  logic         a_wbValid, a_wbRegisterWriteEnable, a_wbIllegal;
  logic [1:0]   a_wbSelect;
  logic [3:0]   a_retireCount;

  always #5 clock = ~clock;

  pipelined_control_unit dut (
    .clock(clock), .resetN(resetN), .idValid(idValid), .idOpcode(idOpcode),
    .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd), .flushEx(flushEx), .freeze(freeze),
    .idStall(idStall), .exValid(exValid), .exBranchEnable(exBranchEnable),
    .exJumpEnable(exJumpEnable), .exImmediateEnable(exImmediateEnable),
    .exAluOperation(exAluOperation), .exRd(exRd), .memValid(memValid),
    .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable), .memRd(memRd),
    .wbValid(wbValid), .wbRegisterWriteEnable(wbRegisterWriteEnable),
    .wbIllegal(wbIllegal), .wbSelect(wbSelect), .wbRd(wbRd), .retireCount(retireCount)
  );

  pipelined_control_unit #(.EXTENDED_OPCODES(1'b0), .RETIRE_COUNT_WIDTH(4)) dut_alt (
    .clock(clock), .resetN(resetN), .idValid(idValid), .idOpcode(idOpcode),
    .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd), .flushEx(flushEx), .freeze(freeze),
    .idStall(a_idStall), .exValid(a_exValid), .exBranchEnable(a_exBranchEnable),
    .exJumpEnable(a_exJumpEnable), .exImmediateEnable(a_exImmediateEnable),
    .exAluOperation(a_exAluOperation), .exRd(a_exRd), .memValid(a_memValid),
    .memReadEnable(a_memReadEnable), .memWriteEnable(a_memWriteEnable), .memRd(a_memRd),
    .wbValid(a_wbValid), .wbRegisterWriteEnable(a_wbRegisterWriteEnable),
    .wbIllegal(a_wbIllegal), .wbSelect(a_wbSelect), .wbRd(a_wbRd),
    .retireCount(a_retireCount)
  );

  // ext marks FENCE/SYSTEM, which the second instance treats as illegal.
  typedef struct packed {
    logic [6:0] opcode;
    logic       branch, jump, mem_read, mem_write, reg_write, imm;
    logic [1:0] alu_op, wb_sel;
    logic       uses_rs1, uses_rs2, illegal, ext;
  } dec_t;

  typedef struct packed {
    logic         valid;
    dec_t         d;
    logic [W-1:0] rd;
  } stage_t;

  typedef struct {
    int     due;
    stage_t s;
  } wb_exp_t;

  dec_t        vec [13];
  wb_exp_t     wb_q[$];
  stage_t      ex_m, mem_m, wb_m;
  int          adv;
  int unsigned exp_retire;
  logic [3:0]  exp_retire_alt;
  int          checks = 0;
  int          errors = 0;

  function automatic dec_t mk(input logic [6:0] op, input logic [5:0] flags,
                              input logic [1:0] alu, input logic [1:0] wb,
                              input logic [1:0] uses, input logic ill, input logic ext);
    dec_t r;
    r.opcode = op;
    {r.branch, r.jump, r.mem_read, r.mem_write, r.reg_write, r.imm} = flags;
    r.alu_op = alu;
    r.wb_sel = wb;
    {r.uses_rs1, r.uses_rs2} = uses;
    r.illegal = ill;
    r.ext = ext;
    return r;
  endfunction

  function automatic dec_t lookup(input logic [6:0] op);
    dec_t r;
    r = '0;
    r.opcode = op;
    r.illegal = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (vec[i].opcode == op) r = vec[i];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check the combinational stall, advance the model, then compare
  // every stage 1ns after the edge.
  task automatic tick();
    dec_t    d;
    logic    exp_stall, accept;
    stage_t  nx;
    wb_exp_t e;
    #1;
    d = lookup(idOpcode);
    exp_stall = idValid && ex_m.valid && ex_m.d.mem_read && (ex_m.rd != '0) &&
                (((ex_m.rd == idRs1) && d.uses_rs1) || ((ex_m.rd == idRs2) && d.uses_rs2));
    if (resetN) begin
      check("id_stall", 64'(idStall), 64'(exp_stall));
      check("alt_id_stall", 64'(a_idStall), 64'(exp_stall));
    end
    accept = resetN && !freeze && !flushEx && !exp_stall && idValid;
    @(posedge clock);
    if (!resetN) begin
      ex_m = '0; mem_m = '0; wb_m = '0;
      wb_q.delete();
      exp_retire = 0;
      exp_retire_alt = '0;
    end else if (!freeze) begin
      if (wb_m.valid && !wb_m.d.illegal) exp_retire++;
      if (wb_m.valid && !wb_m.d.illegal && !wb_m.d.ext) exp_retire_alt++;
      adv++;
      if (wb_q.size() > 0 && wb_q[0].due == adv) wb_m = wb_q.pop_front().s;
      else wb_m = '0;
      mem_m = ex_m;
      nx = '0;
      if (accept) begin
        nx.valid = 1'b1;
        nx.d = d;
        nx.rd = d.reg_write ? idRd : '0;
        e.due = adv + 2;
        e.s = nx;
        wb_q.push_back(e);
      end
      ex_m = nx;
    end
    #1;
    check("ex_valid", 64'(exValid), 64'(ex_m.valid));
    check("ex_branch", 64'(exBranchEnable), 64'(ex_m.d.branch));
    check("ex_jump", 64'(exJumpEnable), 64'(ex_m.d.jump));
    check("ex_imm", 64'(exImmediateEnable), 64'(ex_m.d.imm));
    check("ex_alu_op", 64'(exAluOperation), 64'(ex_m.d.alu_op));
    check("ex_rd", 64'(exRd), 64'(ex_m.rd));
    check("mem_valid", 64'(memValid), 64'(mem_m.valid));
    check("mem_read", 64'(memReadEnable), 64'(mem_m.d.mem_read));
    check("mem_write", 64'(memWriteEnable), 64'(mem_m.d.mem_write));
    check("mem_rd", 64'(memRd), 64'(mem_m.rd));
    check("wb_valid", 64'(wbValid), 64'(wb_m.valid));
    check("wb_reg_write", 64'(wbRegisterWriteEnable), 64'(wb_m.d.reg_write));
    check("wb_illegal", 64'(wbIllegal), 64'(wb_m.d.illegal));
    check("wb_select", 64'(wbSelect), 64'(wb_m.d.wb_sel));
    check("wb_rd", 64'(wbRd), 64'(wb_m.rd));
    check("retire_count", 64'(retireCount), 64'(exp_retire));
    check("alt_ex_valid", 64'(a_exValid), 64'(ex_m.valid));
    check("alt_wb_valid", 64'(a_wbValid), 64'(wb_m.valid));
    check("alt_wb_illegal", 64'(a_wbIllegal), 64'(wb_m.d.illegal || wb_m.d.ext));
    check("alt_retire_count", 64'(a_retireCount), 64'(exp_retire_alt));
  endtask

  task automatic issue(input logic [6:0] op, input logic [W-1:0] rd,
                       input logic [W-1:0] rs1, input logic [W-1:0] rs2);
    idValid = 1'b1; idOpcode = op; idRd = rd; idRs1 = rs1; idRs2 = rs2;
    tick();
  endtask

  task automatic idle(input int n);
    idValid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned base;
    logic [3:0]  base_alt, tgt_alt;
    int          k;

    vec[0]  = mk(7'b0110011, 6'b000010, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0);
    vec[1]  = mk(7'b0010011, 6'b000011, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0);
    vec[2]  = mk(7'b0000011, 6'b001011, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0);
    vec[3]  = mk(7'b1100111, 6'b110011, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0);
    vec[4]  = mk(7'b0100011, 6'b000101, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
    vec[5]  = mk(7'b1100011, 6'b100000, 2'b01, 2'b00, 2'b11, 1'b0, 1'b0);
    vec[6]  = mk(7'b0110111, 6'b000011, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    vec[7]  = mk(7'b0010111, 6'b000011, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    vec[8]  = mk(7'b1101111, 6'b110011, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
    vec[9]  = mk(7'b0001111, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    vec[10] = mk(7'b1110011, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    vec[11] = mk(7'b1111111, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    vec[12] = mk(7'b0000000, 6'b000000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);

    ex_m = '0; mem_m = '0; wb_m = '0;
    adv = 0; exp_retire = 0; exp_retire_alt = '0;
    resetN = 1'b0; freeze = 1'b0; flushEx = 1'b0;
    idValid = 1'b1; idOpcode = OP_R; idRd = 5'd3; idRs1 = 5'd1; idRs2 = 5'd2;

    // Reset held two cycles with a valid R-type in ID.
    tick();
    tick();
    check("reset_outputs", 64'({idStall, exValid, exBranchEnable, exJumpEnable,
          exImmediateEnable, exAluOperation, exRd, memValid, memReadEnable,
          memWriteEnable, memRd, wbValid, wbRegisterWriteEnable, wbIllegal,
          wbSelect, wbRd}), 64'd0);
    check("reset_retire", 64'(retireCount), 64'd0);
    resetN = 1'b1;
    tick();
    check("release_alu_op", 64'(exAluOperation), 64'(2'b10));
    check("release_ex_rd", 64'(exRd), 64'd3);
    idle(4);

    // Pipeline walk: LW x5 then ADDI x6.
    base = exp_retire;
    issue(OP_LOAD, 5'd5, 5'd1, 5'd0);
    issue(OP_IMM, 5'd6, 5'd2, 5'd0);
    check("walk_mem_read", 64'(memReadEnable), 64'd1);
    idle(1);
    check("walk_lw_wb_select", 64'(wbSelect), 64'(2'b01));
    check("walk_lw_wb_rd", 64'(wbRd), 64'd5);
    idle(1);
    check("walk_addi_wb_select", 64'(wbSelect), 64'(2'b00));
    check("walk_addi_wb_rd", 64'(wbRd), 64'd6);
    idle(2);
    check("walk_retired_two", 64'(retireCount), 64'(base + 2));

    // Load-use: one stall cycle, then the re-presented ADD is accepted.
    issue(OP_LOAD, 5'd5, 5'd1, 5'd0);
    idValid = 1'b1; idOpcode = OP_R; idRd = 5'd7; idRs1 = 5'd5; idRs2 = 5'd1;
    #1 check("load_use_stall", 64'(idStall), 64'd1);
    tick();
    check("load_use_bubble", 64'(exValid), 64'd0);
    #1 check("load_use_released", 64'(idStall), 64'd0);
    tick();
    check("load_use_accept", 64'(exRd), 64'd7);
    idle(3);

    // No stall: load to x0 with rs1=x0, and LUI naming x5 in its unused fields.
    issue(OP_LOAD, 5'd0, 5'd1, 5'd0);
    idValid = 1'b1; idOpcode = OP_R; idRd = 5'd8; idRs1 = 5'd0; idRs2 = 5'd0;
    #1 check("x0_no_stall", 64'(idStall), 64'd0);
    tick();
    idle(3);
    issue(OP_LOAD, 5'd5, 5'd1, 5'd0);
    idValid = 1'b1; idOpcode = OP_LUI; idRd = 5'd9; idRs1 = 5'd5; idRs2 = 5'd5;
    #1 check("lui_no_stall", 64'(idStall), 64'd0);
    tick();
    idle(3);

    // Flush and stall together: flush wins with a bubble.
    issue(OP_LOAD, 5'd5, 5'd1, 5'd0);
    idValid = 1'b1; idOpcode = OP_R; idRd = 5'd7; idRs1 = 5'd5; idRs2 = 5'd1;
    flushEx = 1'b1;
    tick();
    flushEx = 1'b0;
    check("flush_stall_bubble", 64'(exValid), 64'd0);
    idle(3);

    // Branch flush: BEQ in EX kills the JAL in ID.
    issue(OP_BRANCH, 5'd0, 5'd1, 5'd2);
    idValid = 1'b1; idOpcode = OP_JAL; idRd = 5'd9; idRs1 = 5'd0; idRs2 = 5'd0;
    flushEx = 1'b1;
    tick();
    flushEx = 1'b0;
    check("flush_jal_killed", 64'(exValid), 64'd0);
    check("flush_beq_in_mem", 64'(memValid), 64'd1);
    idle(4);

    // Freeze for three cycles with a pending flush, released one cycle later.
    issue(OP_IMM, 5'd10, 5'd1, 5'd0);
    issue(OP_IMM, 5'd11, 5'd1, 5'd0);
    issue(OP_LOAD, 5'd12, 5'd3, 5'd0);
    base = exp_retire;
    freeze = 1'b1; flushEx = 1'b1;
    idValid = 1'b1; idOpcode = OP_R; idRd = 5'd13; idRs1 = 5'd1; idRs2 = 5'd2;
    repeat (3) tick();
    check("freeze_retire_held", 64'(retireCount), 64'(base));
    check("freeze_wb_rd_held", 64'(wbRd), 64'd10);
    freeze = 1'b0;
    tick();
    flushEx = 1'b0;
    idle(5);

    // Illegal opcode, and FENCE on the non-extended instance.
    base = exp_retire;
    issue(7'b1111111, 5'd4, 5'd0, 5'd0);
    idle(2);
    check("illegal_wb_flag", 64'(wbIllegal), 64'd1);
    check("illegal_no_write", 64'(wbRegisterWriteEnable), 64'd0);
    idle(2);
    check("illegal_not_retired", 64'(retireCount), 64'(base));
    issue(OP_FENCE, 5'd4, 5'd0, 5'd0);
    idle(2);
    check("fence_legal", 64'(wbIllegal), 64'd0);
    check("fence_alt_illegal", 64'(a_wbIllegal), 64'd1);
    idle(2);

    // Decode table applied back to back.
    for (int i = 0; i < 13; i++) begin
      issue(vec[i].opcode, 5'(i + 1), 5'd0, 5'd0);
    end
    idle(4);

    // Seventeen retirements wrap the 4-bit counter to base + 1.
    base_alt = exp_retire_alt;
    for (int i = 0; i < 17; i++) issue(OP_IMM, 5'd1, 5'd0, 5'd0);
    idle(4);
    tgt_alt = 4'((int'(base_alt) + 17) % 16);
    check("retire_wrap", 64'(a_retireCount), 64'(tgt_alt));

    // Random traffic with hazards, flushes and freezes.
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 12));
      idValid  = ($urandom_range(0, 9) < 8);
      idOpcode = ($urandom_range(0, 15) == 0) ? 7'($urandom()) : vec[k].opcode;
      idRd     = 5'($urandom_range(0, 7));
      idRs1    = 5'($urandom_range(0, 7));
      idRs2    = 5'($urandom_range(0, 7));
      flushEx  = ($urandom_range(0, 9) == 0);
      freeze   = ($urandom_range(0, 9) == 0);
      tick();
    end
    flushEx = 1'b0; freeze = 1'b0;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
